// File: rtl/level_meter_defs_pkg.sv
// Shared definitions for level_meter_scheduler: FSM state encoding,
// the channel-tag width helper and the default level width.
package level_meter_defs;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_OUTPUT = 2'd2
  } state_t;

  // Tag width never collapses to zero, even for a single channel.
  function automatic int chw_f(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/level_meter_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester found
// when searching ptr, ptr+1, ... modulo n.
module rr_arbiter
  import level_meter_defs::*;
#(
  parameter  int n  = 2,
  localparam int pw = chw_f(n)
) (
  input  logic [n-1:0]  req,
  input  logic [pw-1:0] ptr,
  output logic [pw-1:0] grant,
  output logic          any_req
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    grant   = '0;
    any_req = |req;
    for (int i = n - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % n]) grant = pw'((int'(ptr) + i) % n);
    end
  end

endmodule

// File: rtl/level_meter_scheduler.sv
// Shares one output path between per-channel level streams with round-robin
// arbitration and per-channel peak hold/decay (LEVEL_METER_PEAK_HOLD_EN).
module level_meter_scheduler
  import level_meter_defs::*;
#(
  parameter  int               width      = DEFAULT_WIDTH,
  parameter  int               channels   = 2,
  parameter  int               hold_count = 8,
  parameter  logic [width-1:0] decay_step = 16'h0100,
  localparam int               chw        = chw_f(channels)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [channels-1:0]       i_valid,
  output logic [channels-1:0]       i_ready,
  input  logic [channels*width-1:0] i_value,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [chw-1:0]            o_channel,
  output logic [width-1:0]          o_level,
  output logic [width-1:0]          o_peak
);

  state_t           state, state_nxt;
  logic [chw-1:0]   rr_ptr;
  logic [chw-1:0]   grant;
  logic             any_req;
  logic [width-1:0] sample;
  logic [chw-1:0]   ch;
  logic [width-1:0] peak_upd;

  rr_arbiter #(.n(channels)) u_arb (
    .req     (i_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .any_req (any_req)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_UPDATE;
      S_UPDATE: state_nxt = S_OUTPUT;
      S_OUTPUT: if (o_ready) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Ready is gated by reset so no transfer appears accepted while held in reset.
  always_comb begin
    i_ready = '0;
    if (state == S_IDLE && any_req && reset) i_ready[grant] = 1'b1;
    o_valid = (state == S_OUTPUT);
  end

  // Capture stage (S_IDLE transfer) and output load stage (S_UPDATE).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      sample    <= '0;
      ch        <= '0;
      o_channel <= '0;
      o_level   <= '0;
      o_peak    <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        sample <= i_value[int'(grant)*width +: width];
        ch     <= grant;
        rr_ptr <= chw'((int'(grant) + 1) % channels);
      end
      if (state == S_UPDATE) begin
        o_channel <= ch;
        o_level   <= sample;
        o_peak    <= peak_upd;
      end
    end
  end

`ifdef LEVEL_METER_PEAK_HOLD_EN
  localparam int hw = chw_f(hold_count + 1);

  logic [width-1:0] peak_r [channels];
  logic [hw-1:0]    hold_r [channels];
  logic [width-1:0] peak_cur;
  logic [hw-1:0]    hold_cur, hold_upd;

  function automatic logic [width-1:0] sat_sub(input logic [width-1:0] a,
                                                input logic [width-1:0] b);
    return (a > b) ? a - b : '0;
  endfunction

  function automatic logic [width-1:0] max_u(input logic [width-1:0] a,
                                              input logic [width-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    peak_cur = peak_r[ch];
    hold_cur = hold_r[ch];
    peak_upd = peak_cur;
    hold_upd = hold_cur;
    if (sample >= peak_cur) begin
      peak_upd = sample;
      hold_upd = hw'(hold_count);
    end else if (hold_cur != '0) begin
      hold_upd = hold_cur - hw'(1);
    end else begin
      peak_upd = max_u(sat_sub(peak_cur, decay_step), sample);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < channels; k++) begin
        peak_r[k] <= '0;
        hold_r[k] <= '0;
      end
    end else if (state == S_UPDATE) begin
      peak_r[ch] <= peak_upd;
      hold_r[ch] <= hold_upd;
    end
  end
`else
  assign peak_upd = sample;
`endif

endmodule

// File: tb/tb_level_meter_scheduler.sv
// Self-checking bench for level_meter_scheduler: directed sequences, a
// vector table for peak hold/decay and randomized traffic vs a queue model.
module tb_level_meter_scheduler;

  localparam int          HOLD  = 2;
  localparam logic [15:0] DECAY = 16'h0100;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  i_valid = '0;
  logic [1:0]  i_ready;
  logic [31:0] i_value = '0;
  logic        o_valid;
  logic        o_ready = 1'b0;
  logic [0:0]  o_channel;
  logic [15:0] o_level, o_peak;

  always #5 clk = ~clk;

  level_meter_scheduler #(
    .width(16), .channels(2), .hold_count(HOLD), .decay_step(DECAY)
  ) dut (
    .clk(clk), .reset(reset), .i_valid(i_valid), .i_ready(i_ready),
    .i_value(i_value), .o_valid(o_valid), .o_ready(o_ready),
    .o_channel(o_channel), .o_level(o_level), .o_peak(o_peak)
  );

  typedef struct {
    int          ch;
    logic [15:0] level;
    logic [15:0] peak;
  } rec_t;

  typedef struct {
    int          ch;
    logic [15:0] value;
    logic [15:0] peak_en;
    logic [15:0] peak_dis;
  } vec_t;

  rec_t        exp_q[$];
  rec_t        got[$];
  int          n_cmp = 0, n_fail = 0;
  int          age = 0, rr = 0, cyc = 0;
  int          rdy0_cnt = 0, first_ov = -1;
  bit          auto_clear = 1'b1;
  logic [15:0] m_pk[2];
  int          m_hd[2];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_grant();
    for (int off = 0; off < 2; off++)
      if (i_valid[(rr + off) % 2]) return (rr + off) % 2;
    return -1;
  endfunction

  function automatic logic [15:0] model_peak(input int k, input logic [15:0] s);
`ifdef LEVEL_METER_PEAK_HOLD_EN
    int d;
    if (s >= m_pk[k]) begin
      m_pk[k] = s;
      m_hd[k] = HOLD;
    end else if (m_hd[k] > 0) begin
      m_hd[k]--;
    end else begin
      d = int'(m_pk[k]) - int'(DECAY);
      if (d < int'(s)) d = int'(s);
      m_pk[k] = 16'(d);
    end
    return m_pk[k];
`else
    m_pk[k] = s;
    return s;
`endif
  endfunction

  task automatic model_clear();
    m_pk = '{16'h0, 16'h0};
    m_hd = '{0, 0};
    rr = 0;
    age = 0;
    exp_q.delete();
  endtask

  task automatic present(input int k, input logic [15:0] v);
    i_value[k*16 +: 16] = v;
    i_valid[k] = 1'b1;
  endtask

  // One clock: called just after a rising edge with inputs already applied.
  task automatic cycle();
    int   g;
    bit   acc, exp_ov, cons;
    rec_t a, r;
    #1;
    g   = model_grant();
    acc = (exp_q.size() == 0) && (g >= 0);
    check("i_ready", 32'(i_ready), acc ? (32'd1 << g) : 32'd0);
    if (i_ready[0]) rdy0_cnt++;
    exp_ov = (exp_q.size() > 0) && (age >= 1);
    check("o_valid", 32'(o_valid), 32'(exp_ov));
    if (o_valid && first_ov < 0) first_ov = cyc;
    if (exp_ov) begin
      check("o_channel", 32'(o_channel), 32'(exp_q[0].ch));
      check("o_level", 32'(o_level), 32'(exp_q[0].level));
      check("o_peak", 32'(o_peak), 32'(exp_q[0].peak));
    end
    cons = exp_ov && o_ready;
    a = '{int'(o_channel), o_level, o_peak};
    @(posedge clk);
    #1;
    cyc++;
    age++;
    if (cons) begin
      void'(exp_q.pop_front());
      got.push_back(a);
    end
    if (acc) begin
      r.ch    = g;
      r.level = i_value[g*16 +: 16];
      r.peak  = model_peak(g, r.level);
      exp_q.push_back(r);
      age = 0;
      rr  = (g + 1) % 2;
      if (auto_clear) i_valid[g] = 1'b0;
    end
  endtask

  task automatic run_records(input int n, input int budget);
    int tgt, c;
    tgt = got.size() + n;
    c = 0;
    while (got.size() < tgt && c < budget) begin
      cycle();
      c++;
    end
    check("record_count", 32'(got.size()), 32'(tgt));
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    i_valid = 2'b11;
    #1;
    model_clear();
    check("rst_i_ready", 32'(i_ready), 32'd0);
    check("rst_o_valid", 32'(o_valid), 32'd0);
    check("rst_o_channel", 32'(o_channel), 32'd0);
    check("rst_o_level", 32'(o_level), 32'd0);
    check("rst_o_peak", 32'(o_peak), 32'd0);
    @(posedge clk);
    #1;
    check("rst_o_valid_hold", 32'(o_valid), 32'd0);
    i_valid = '0;
    reset = 1'b1;
  endtask

  vec_t tbl[9];

  initial begin
    int start, guard;
    int gsz;

    tbl[0] = '{0, 16'h8000, 16'h8000, 16'h8000};
    tbl[1] = '{0, 16'h1000, 16'h8000, 16'h1000};
    tbl[2] = '{0, 16'h1000, 16'h8000, 16'h1000};
    tbl[3] = '{0, 16'h1000, 16'h7F00, 16'h1000};
    tbl[4] = '{0, 16'h1000, 16'h7E00, 16'h1000};
    tbl[5] = '{1, 16'h0080, 16'h0080, 16'h0080};
    tbl[6] = '{1, 16'h0010, 16'h0080, 16'h0010};
    tbl[7] = '{1, 16'h0010, 16'h0080, 16'h0010};
    tbl[8] = '{1, 16'h0010, 16'h0010, 16'h0010};

    @(posedge clk);
    #1;
    apply_reset();

    // First record: latency and single-cycle ready pulse.
    o_ready  = 1'b1;
    rdy0_cnt = 0;
    first_ov = -1;
    present(0, 16'h3333);
    start = cyc;
    run_records(1, 20);
    check("first_ch", 32'(got[$].ch), 32'd0);
    check("first_level", 32'(got[$].level), 32'h3333);
    check("first_peak", 32'(got[$].peak), 32'h3333);
    check("latency", 32'(first_ov - start), 32'd2);
    check("ready0_cycles", 32'(rdy0_cnt), 32'd1);

    // Output stall with both channels requesting.
    o_ready = 1'b0;
    present(1, 16'h2222);
    present(0, 16'h0444);
    guard = 0;
    while (!(exp_q.size() > 0 && age >= 1) && guard < 10) begin
      cycle();
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", 32'(o_valid), 32'd1);
      check("stall_level", 32'(o_level), 32'h2222);
      check("stall_ready", 32'(i_ready), 32'd0);
      cycle();
    end
    o_ready = 1'b1;
    run_records(1, 5);
    check("stall_ch", 32'(got[$].ch), 32'd1);
    run_records(1, 10);

    // Reset while the record is in S_UPDATE.
    present(1, 16'h0555);
    gsz = got.size();
    guard = 0;
    while (exp_q.size() == 0 && guard < 10) begin
      cycle();
      guard++;
    end
    reset = 1'b0;
    #1;
    check("midrst_o_valid", 32'(o_valid), 32'd0);
    check("midrst_o_level", 32'(o_level), 32'd0);
    check("midrst_o_peak", 32'(o_peak), 32'd0);
    check("midrst_i_ready", 32'(i_ready), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    check("midrst_o_valid2", 32'(o_valid), 32'd0);
    reset = 1'b1;
    check("midrst_no_record", 32'(got.size()), 32'(gsz));
    present(0, 16'h0010);
    present(1, 16'h0020);
    run_records(1, 10);
    check("midrst_grant", 32'(got[$].ch), 32'd0);
    check("midrst_peak", 32'(got[$].peak), 32'h0010);
    run_records(1, 10);

    // Peak hold / decay / floor vector table.
    apply_reset();
    foreach (tbl[i]) begin
      present(tbl[i].ch, tbl[i].value);
      run_records(1, 10);
      check("tbl_ch", 32'(got[$].ch), 32'(tbl[i].ch));
      check("tbl_level", 32'(got[$].level), 32'(tbl[i].value));
`ifdef LEVEL_METER_PEAK_HOLD_EN
      check("tbl_peak", 32'(got[$].peak), 32'(tbl[i].peak_en));
`else
      check("tbl_peak", 32'(got[$].peak), 32'(tbl[i].peak_dis));
`endif
    end

    // Both channels continuously valid: strict alternation.
    auto_clear = 1'b0;
    present(0, 16'h1111);
    present(1, 16'h2222);
    run_records(4, 30);
    i_valid = '0;
    auto_clear = 1'b1;
    for (int i = 0; i < 4; i++)
      check("alt_ch", 32'(got[got.size() - 4 + i].ch), 32'(i % 2));

    // Randomized traffic against the queue model.
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 2; k++) begin
        if (!i_valid[k] && $urandom_range(0, 2) == 0) begin
          if ($urandom_range(0, 3) == 0) present(k, 16'($urandom));
          else                           present(k, 16'($urandom_range(0, 16'h0300)));
        end
      end
      o_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
